mandel_iter: RTL and testbench

Escape-time iteration engine for one pixel: accepts a complex point c in signed fixed point, iterates z ← z² + c from z = 0 at one iteration per clock, and returns the escape iteration count. It is the producer for the colour mapping stage. Its `iter_o`/`max_iter_o` pair drives that stage's iteration and max-iteration inputs. It sits between the pixel-coordinate generator (upstream, valid/ready) and the colour mapper (downstream, valid/ready).

---
 rtl/mandel_iter_if.sv | 26 ++
 rtl/mandel_iter.sv | 162 ++++++++++++++++
 tb/tb_mandel_iter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mandel_iter_if.sv
// Handshake and data bundle for the mandel_iter escape-time engine:
// upstream point (c, limit) with valid/ready, downstream result with valid/ready.
interface mandel_iter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ITER_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] c_re_i;
  logic signed [DATA_WIDTH-1:0] c_im_i;
  logic [MAX_ITER_WIDTH-1:0]    max_iter_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [MAX_ITER_WIDTH-1:0]    iter_o;
  logic [MAX_ITER_WIDTH-1:0]    max_iter_o;
  logic                         out_valid_o;
  logic                         out_ready_i;

  modport slave (
    input  c_re_i, c_im_i, max_iter_i, in_valid_i, out_ready_i,
    output in_ready_o, iter_o, max_iter_o, out_valid_o
  );

  modport master (
    output c_re_i, c_im_i, max_iter_i, in_valid_i, out_ready_i,
    input  in_ready_o, iter_o, max_iter_o, out_valid_o
  );
endinterface

// File: rtl/mandel_iter.sv
// Escape-time iteration engine for one pixel: z <- z^2 + c, one step per clock.
// Optional interior shortcut (main cardioid / period-2 bulb) under MANDEL_INTERIOR_SKIP_EN.
module mandel_iter #(
  parameter int DATA_WIDTH     = 32,
  parameter int FRAC_BITS      = 28,
  parameter int MAX_ITER_WIDTH = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  mandel_iter_if.slave bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW:0] ESC_LIMIT = (PW + 1)'(4) << (2 * FRAC_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
  logic signed [DATA_WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
  logic [MAX_ITER_WIDTH-1:0]    max_q, max_d, cnt_q, cnt_d, iter_q, iter_d;

  logic signed [PW-1:0]         sq_re_s, sq_im_s, cross_s;
  logic [PW:0]                  mag2_s;
  logic                         escape_s;
  logic signed [DATA_WIDTH-1:0] nz_re_s, nz_im_s;
  logic                         accept_s;
  logic                         skip_hit_s;

  // Squares and cross product at full double width; sum kept one bit wider so it cannot wrap.
  assign sq_re_s  = PW'(z_re_q) * PW'(z_re_q);
  assign sq_im_s  = PW'(z_im_q) * PW'(z_im_q);
  assign cross_s  = PW'(z_re_q) * PW'(z_im_q);
  assign mag2_s   = {1'b0, sq_re_s} + {1'b0, sq_im_s};
  assign escape_s = (mag2_s > ESC_LIMIT);
  assign nz_re_s  = DATA_WIDTH'((sq_re_s - sq_im_s) >>> FRAC_BITS) + c_re_q;
  assign nz_im_s  = DATA_WIDTH'((cross_s <<< 1) >>> FRAC_BITS) + c_im_q;

  assign accept_s = (state_q == IDLE) && bus.in_valid_i;

`ifdef MANDEL_INTERIOR_SKIP_EN
  localparam int QW = 4 * DATA_WIDTH;
  localparam logic signed [DATA_WIDTH:0] QTR_C  = $signed((DATA_WIDTH + 1)'(1) << (FRAC_BITS - 2));
  localparam logic signed [DATA_WIDTH:0] ONE_C  = $signed((DATA_WIDTH + 1)'(1) << FRAC_BITS);
  localparam logic signed [QW-1:0]       BULB_R = $signed(QW'(1) << (2 * FRAC_BITS - 4));

  logic signed [DATA_WIDTH:0] xm_s, xp_s;
  logic signed [QW-1:0]       y2_s, xm2_s, xp2_s, q_s, qs_s, lhs_s, rhs_s;
  logic                       interior_s;
  logic                       skip_q;

  // Interior tests on the incoming c: values with 2*FRAC_BITS fraction bits unless rescaled.
  assign xm_s       = (DATA_WIDTH + 1)'(bus.c_re_i) - QTR_C;
  assign xp_s       = (DATA_WIDTH + 1)'(bus.c_re_i) + ONE_C;
  assign y2_s       = QW'(bus.c_im_i) * QW'(bus.c_im_i);
  assign xm2_s      = QW'(xm_s) * QW'(xm_s);
  assign xp2_s      = QW'(xp_s) * QW'(xp_s);
  assign q_s        = (xm2_s + y2_s) >>> FRAC_BITS;
  assign qs_s       = q_s + QW'(xm_s);
  assign lhs_s      = q_s * qs_s;
  assign rhs_s      = y2_s >>> 2;
  assign interior_s = (lhs_s < rhs_s) || ((xp2_s + y2_s) < BULB_R);

  // Interior flag captured alongside c at acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skip_q <= 1'b0;
    end else if (accept_s) begin
      skip_q <= interior_s;
    end else begin
      skip_q <= skip_q;
    end
  end

  assign skip_hit_s = skip_q;
`else
  assign skip_hit_s = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      c_re_q  <= {DATA_WIDTH{1'b0}};
      c_im_q  <= {DATA_WIDTH{1'b0}};
      z_re_q  <= {DATA_WIDTH{1'b0}};
      z_im_q  <= {DATA_WIDTH{1'b0}};
      max_q   <= {MAX_ITER_WIDTH{1'b0}};
      cnt_q   <= {MAX_ITER_WIDTH{1'b0}};
      iter_q  <= {MAX_ITER_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      c_re_q  <= c_re_d;
      c_im_q  <= c_im_d;
      z_re_q  <= z_re_d;
      z_im_q  <= z_im_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
    end
  end

  // Next-state and datapath update; the limit test precedes the increment so the count never wraps.
  always_comb begin
    state_d = state_q;
    c_re_d  = c_re_q;
    c_im_d  = c_im_q;
    z_re_d  = z_re_q;
    z_im_d  = z_im_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = ITER;
          c_re_d  = bus.c_re_i;
          c_im_d  = bus.c_im_i;
          max_d   = bus.max_iter_i;
          z_re_d  = {DATA_WIDTH{1'b0}};
          z_im_d  = {DATA_WIDTH{1'b0}};
          cnt_d   = {MAX_ITER_WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if ((cnt_q == max_q) || skip_hit_s) begin
          state_d = DONE;
          iter_d  = max_q;
        end else if (escape_s) begin
          state_d = DONE;
          iter_d  = cnt_q;
        end else begin
          z_re_d  = nz_re_s;
          z_im_d  = nz_im_s;
          cnt_d   = cnt_q + MAX_ITER_WIDTH'(1);
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.iter_o      = iter_q;
  assign bus.max_iter_o  = max_q;

endmodule

// File: tb/tb_mandel_iter.sv
// Directed, table-driven bench for mandel_iter (Q4.28, 16-bit counts), plus
// hand-written back-pressure and reset sequences.
module tb_mandel_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  mandel_iter_if #(.DATA_WIDTH(32), .MAX_ITER_WIDTH(16)) bus ();

  mandel_iter #(.DATA_WIDTH(32), .FRAC_BITS(28), .MAX_ITER_WIDTH(16)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic signed [31:0] cre;
    logic signed [31:0] cim;
    logic [15:0]        mx;
    int                 exp_iter;
    int                 exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one point, wait for the result, check it, then consume it.
  task automatic run_vec(input vec_t v);
    int lat;
    int busy_err;
    chk({v.name, "_ready_before"}, bus.in_ready_o, 1);
    bus.c_re_i     = v.cre;
    bus.c_im_i     = v.cim;
    bus.max_iter_i = v.mx;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    bus.c_re_i     = $signed($urandom);
    bus.c_im_i     = $signed($urandom);
    bus.max_iter_i = 16'($urandom);
    lat = 1;
    busy_err = 0;
    while (!bus.out_valid_o && lat < 400) begin
      if (bus.in_ready_o) busy_err++;
      tick();
      lat++;
    end
    chk({v.name, "_latency"}, lat, v.exp_lat);
    chk({v.name, "_iter"}, bus.iter_o, v.exp_iter);
    chk({v.name, "_max_iter_o"}, bus.max_iter_o, v.mx);
    chk({v.name, "_busy_ready_low"}, busy_err + (bus.in_ready_o ? 1 : 0), 0);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk({v.name, "_valid_drop"}, bus.out_valid_o, 0);
    chk({v.name, "_ready_after"}, bus.in_ready_o, 1);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{"c_3p0",       32'sh3000_0000, 32'sh0000_0000, 16'd100,   1,   3};
    vecs[1]  = '{"c_1p0",       32'sh1000_0000, 32'sh0000_0000, 16'd100,   3,   5};
    vecs[2]  = '{"c_m2_strict", 32'shE000_0000, 32'sh0000_0000, 16'd100, 100, 102};
    vecs[3]  = '{"max0",        32'sh1800_0000, 32'sh0800_0000, 16'd0,     0,   2};
    vecs[4]  = '{"c_half_half", 32'sh0800_0000, 32'sh0800_0000, 16'd100,   5,   7};
    vecs[5]  = '{"c_2i",        32'sh0000_0000, 32'sh2000_0000, 16'd100,   2,   4};
    vecs[6]  = '{"c_m2p5",      32'shD800_0000, 32'sh0000_0000, 16'd100,   1,   3};
    vecs[7]  = '{"max_all_ones",32'sh3000_0000, 32'sh0000_0000, 16'hFFFF,  1,   3};
`ifdef MANDEL_INTERIOR_SKIP_EN
    vecs[8]  = '{"c_zero",      32'sh0000_0000, 32'sh0000_0000, 16'd100, 100,   2};
    vecs[9]  = '{"c_zero_max5", 32'sh0000_0000, 32'sh0000_0000, 16'd5,     5,   2};
    vecs[10] = '{"c_m1_bulb",   32'shF000_0000, 32'sh0000_0000, 16'd10,   10,   2};
`else
    vecs[8]  = '{"c_zero",      32'sh0000_0000, 32'sh0000_0000, 16'd100, 100, 102};
    vecs[9]  = '{"c_zero_max5", 32'sh0000_0000, 32'sh0000_0000, 16'd5,     5,   7};
    vecs[10] = '{"c_m1_bulb",   32'shF000_0000, 32'sh0000_0000, 16'd10,   10,  12};
`endif
    vecs[11] = '{"after_reset", 32'sh3000_0000, 32'sh0000_0000, 16'd7,     1,   3};

    bus.c_re_i      = 32'sh0;
    bus.c_im_i      = 32'sh0;
    bus.max_iter_i  = 16'd0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_iter", bus.iter_o, 0);
    chk("rst_max_iter", bus.max_iter_o, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
    end

    // Back-pressure: result held for 10 cycles while out_ready_i stays low.
    bus.c_re_i     = 32'sh1000_0000;
    bus.c_im_i     = 32'sh0;
    bus.max_iter_i = 16'd100;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    seen = 0;
    while (!bus.out_valid_o && seen < 50) begin
      tick();
      seen++;
    end
    chk("bp_reached_done", bus.out_valid_o, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_iter_stable", bus.iter_o, 3);
      chk("bp_valid_held", bus.out_valid_o, 1);
      chk("bp_in_ready_low", bus.in_ready_o, 0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk("bp_consumed", bus.out_valid_o, 0);

    // Reset during ITER discards the point.
    bus.c_re_i     = 32'shE000_0000;
    bus.c_im_i     = 32'sh0;
    bus.max_iter_i = 16'd100;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_busy", bus.in_ready_o, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready_o, 1);
    chk("mid_rst_out_valid", bus.out_valid_o, 0);
    chk("mid_rst_iter", bus.iter_o, 0);
    seen = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (bus.out_valid_o) seen++;
    end
    chk("mid_rst_no_result", seen, 0);

    // Reset coincident with an input handshake: point must not be taken.
    bus.c_re_i     = 32'sh3000_0000;
    bus.max_iter_i = 16'd100;
    bus.in_valid_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("rst_hs_in_ready", bus.in_ready_o, 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid_o || !bus.in_ready_o) seen++;
    end
    chk("rst_hs_not_taken", seen, 0);

    run_vec(vecs[11]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
